// File: rtl/reg_commit_checker.sv
// Run-and-check harness between processor and regfile: logs register writes with cycle
// stamps during a window, then scans the regfile against expected data. Option: CHECKER_FAIL_STOP_EN.
module reg_commit_checker #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned CYCLE_WIDTH = 10
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [CYCLE_WIDTH-1:0]                    num_cycles,
    input  logic                                      wr_en,
    input  logic [ADDR_WIDTH-1:0]                     wr_reg,
    input  logic [DATA_WIDTH-1:0]                     wr_data,
    output logic                                      test_mode,
    output logic [ADDR_WIDTH-1:0]                     test_reg,
    input  logic [DATA_WIDTH-1:0]                     rd_data,
    input  logic [DATA_WIDTH-1:0]                     exp_data,
    output logic                                      trace_valid,
    input  logic                                      trace_ready,
    output logic [CYCLE_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] trace_entry,
    output logic                                      trace_overflow,
    output logic                                      busy,
    output logic                                      done,
    output logic [ADDR_WIDTH:0]                       error_count,
    output logic [ADDR_WIDTH-1:0]                     first_fail
);

    localparam int unsigned PTR_W   = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = CYCLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned ERR_W   = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SCAN,
        ST_CMP,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CYCLE_WIDTH-1:0] num_cyc_q, num_cyc_d;
    logic [CYCLE_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]  first_fail_q, first_fail_d;
    logic                   ovf_q, ovf_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ENTRY_W-1:0]     mem_q [TRACE_DEPTH];

    logic push_req, push, pop, full, flush, mismatch;

    // Next-state, scan bookkeeping and trace FIFO control
    always_comb begin
        state_d      = state_q;
        num_cyc_d    = num_cyc_q;
        cyc_cnt_d    = cyc_cnt_q;
        idx_d        = idx_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        ovf_d        = ovf_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        push_req     = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;
        mismatch     = (rd_data != exp_data);
        full         = (count_q == CNT_W'(TRACE_DEPTH));
        pop          = trace_ready && (count_q != '0);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_cyc_d    = num_cycles;
                    cyc_cnt_d    = '0;
                    idx_d        = '0;
                    err_cnt_d    = '0;
                    first_fail_d = '0;
                    ovf_d        = 1'b0;
                    flush        = 1'b1;
                    state_d      = (num_cycles == '0) ? ST_SCAN : ST_RUN;
                end
            end
            ST_RUN: begin
                push_req  = wr_en && (wr_reg != '0);
                cyc_cnt_d = cyc_cnt_q + CYCLE_WIDTH'(1);
                if (cyc_cnt_q == num_cyc_q - CYCLE_WIDTH'(1)) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                state_d = ST_CMP;
            end
            ST_CMP: begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_W'(NUM_REGS)) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (err_cnt_q == '0) begin
                        first_fail_d = idx_q;
                    end
                end
                if (idx_q == ADDR_WIDTH'(NUM_REGS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = ST_SCAN;
                end
`ifdef CHECKER_FAIL_STOP_EN
                if (mismatch) begin
                    idx_d   = idx_q;
                    state_d = ST_DONE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pop frees the slot in the same cycle, so a full FIFO still accepts the push
        push = push_req && (!full || pop);
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State and control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            num_cyc_q    <= '0;
            cyc_cnt_q    <= '0;
            idx_q        <= '0;
            err_cnt_q    <= '0;
            first_fail_q <= '0;
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            num_cyc_q    <= num_cyc_d;
            cyc_cnt_q    <= cyc_cnt_d;
            idx_q        <= idx_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            ovf_q        <= ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Trace storage; contents are don't-care while the count says empty
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cyc_cnt_q, wr_reg, wr_data};
        end
    end

    assign busy           = (state_q == ST_RUN) || (state_q == ST_SCAN) || (state_q == ST_CMP);
    assign done           = (state_q == ST_DONE);
    assign test_mode      = (state_q == ST_SCAN) || (state_q == ST_CMP);
    assign test_reg       = idx_q;
    assign trace_valid    = (count_q != '0);
    assign trace_entry    = trace_valid ? mem_q[rd_ptr_q] : '0;
    assign trace_overflow = ovf_q;
    assign error_count    = err_cnt_q;
    assign first_fail     = first_fail_q;

endmodule

// File: tb/tb_reg_commit_checker.sv
// Scoreboard bench for reg_commit_checker: expected trace entries are queued as writes are
// driven and compared when popped; scan results are checked against a regfile model.
module tb_reg_commit_checker;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;
    localparam int unsigned TD = 16;
    localparam int unsigned CW = 10;
    localparam int unsigned EW = CW + AW + DW;

`ifdef CHECKER_FAIL_STOP_EN
    localparam int EXP_SCAN = 16;
    localparam int EXP_ERRS = 1;
`else
    localparam int EXP_SCAN = 64;
    localparam int EXP_ERRS = 2;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_cycles = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_reg = '0;
    logic [DW-1:0] wr_data = '0;
    logic          test_mode;
    logic [AW-1:0] test_reg;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] exp_data;
    logic          trace_valid;
    logic          trace_ready = 1'b0;
    logic [EW-1:0] trace_entry;
    logic          trace_overflow;
    logic          busy;
    logic          done;
    logic [AW:0]   error_count;
    logic [AW-1:0] first_fail;

    logic [DW-1:0] regf [NR];
    logic [DW-1:0] expm [NR];
    logic [EW-1:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    reg_commit_checker #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .TRACE_DEPTH(TD),
        .CYCLE_WIDTH(CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .num_cycles    (num_cycles),
        .wr_en         (wr_en),
        .wr_reg        (wr_reg),
        .wr_data       (wr_data),
        .test_mode     (test_mode),
        .test_reg      (test_reg),
        .rd_data       (rd_data),
        .exp_data      (exp_data),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_entry   (trace_entry),
        .trace_overflow(trace_overflow),
        .busy          (busy),
        .done          (done),
        .error_count   (error_count),
        .first_fail    (first_fail)
    );

    always #5 clock = ~clock;

    assign rd_data  = regf[test_reg];
    assign exp_data = expm[test_reg];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one RUN-cycle write; r0 writes are never expected in the trace
    task automatic drive_write(input int cyc, input logic [AW-1:0] r, input logic [DW-1:0] d,
                               input bit accepted);
        wr_en   = 1'b1;
        wr_reg  = r;
        wr_data = d;
        if (accepted && r != '0) exp_q.push_back({CW'(cyc), r, d});
    endtask

    task automatic service_trace();
        if (trace_valid) begin
            if (exp_q.size() == 0) check_eq("trace_extra", 64'(trace_valid), 64'd0);
            else check_eq("trace_entry", 64'(trace_entry), 64'(exp_q.pop_front()));
            trace_ready = 1'b1;
        end else begin
            trace_ready = 1'b0;
        end
    endtask

    // Called with the FSM just in SCAN; optionally pulses start mid-scan
    task automatic run_scan(input int start_at);
        int n = 0;
        while (done == 1'b0 && n < 400) begin
            service_trace();
            start = (n == start_at);
            if (start) num_cycles = CW'(5);
            tick();
            n++;
        end
        start       = 1'b0;
        trace_ready = 1'b0;
        check_eq("scan_len", 64'(n), 64'(EXP_SCAN));
        check_eq("done", 64'(done), 64'd1);
        check_eq("done_test_mode", 64'(test_mode), 64'd0);
        check_eq("done_busy", 64'(busy), 64'd0);
        check_eq("error_count", 64'(error_count), 64'(EXP_ERRS));
        check_eq("first_fail", 64'(first_fail), 64'd7);
        check_eq("trace_left", 64'(exp_q.size()), 64'd0);
        check_eq("trace_empty", 64'(trace_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < int'(NR); i++) begin
            regf[i] = DW'(i) * 32'h0101_0101 ^ 32'h0000_00A5;
            expm[i] = regf[i];
        end
        regf[7]  = 32'd10;
        expm[7]  = 32'd9;
        expm[20] = regf[20] + 32'd1;

        // Reset state
        tick();
        tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_test_mode", 64'(test_mode), 64'd0);
        check_eq("rst_test_reg", 64'(test_reg), 64'd0);
        check_eq("rst_valid", 64'(trace_valid), 64'd0);
        check_eq("rst_ovf", 64'(trace_overflow), 64'd0);
        check_eq("rst_errs", 64'(error_count), 64'd0);
        check_eq("rst_first", 64'(first_fail), 64'd0);
        check_eq("rst_entry", 64'(trace_entry), 64'd0);
        reset = 1'b0;
        tick();

        // Window of 8 cycles with two logged writes and one r0 write
        start = 1'b1;
        num_cycles = CW'(8);
        tick();
        start = 1'b0;
        check_eq("run_busy", 64'(busy), 64'd1);
        check_eq("run_test_mode", 64'(test_mode), 64'd0);
        for (int c = 0; c < 8; c++) begin
            wr_en = 1'b0;
            if (c == 0) drive_write(c, 5'd0, 32'h55, 1'b1);
            if (c == 1) check_eq("r0_not_logged", 64'(trace_valid), 64'd0);
            if (c == 2) drive_write(c, 5'd3, 32'h11, 1'b1);
            if (c == 6) drive_write(c, 5'd5, 32'hFFFF_FFFF, 1'b1);
            if (c == 7) check_eq("run_last_cycle", 64'(test_mode), 64'd0);
            tick();
        end
        wr_en = 1'b0;
        check_eq("scan_entry", 64'(test_mode), 64'd1);
        run_scan(-1);

        // FIFO fill, full push+pop, then overflow
        start = 1'b1;
        num_cycles = CW'(40);
        tick();
        start = 1'b0;
        check_eq("restart_ovf_clear", 64'(trace_overflow), 64'd0);
        for (int c = 0; c < 40; c++) begin
            wr_en = 1'b0;
            trace_ready = 1'b0;
            if (c < 16) drive_write(c, AW'(c % 31 + 1), DW'(c) + 32'h100, 1'b1);
            if (c == 16) begin
                service_trace();
                drive_write(c, AW'(c % 31 + 1), DW'(c) + 32'h100, 1'b1);
            end
            if (c == 17) check_eq("full_pushpop_no_ovf", 64'(trace_overflow), 64'd0);
            if (c >= 17 && c < 20) drive_write(c, AW'(c % 31 + 1), DW'(c) + 32'h100, 1'b0);
            if (c == 18) check_eq("overflow_set", 64'(trace_overflow), 64'd1);
            if (c >= 21) service_trace();
            tick();
        end
        wr_en = 1'b0;
        trace_ready = 1'b0;
        check_eq("overflow_sticky", 64'(trace_overflow), 64'd1);
        run_scan(-1);

        // Empty window goes straight to SCAN; start during scan is ignored
        start = 1'b1;
        num_cycles = CW'(0);
        tick();
        start = 1'b0;
        check_eq("zero_win_scan", 64'(test_mode), 64'd1);
        check_eq("zero_win_no_trace", 64'(trace_valid), 64'd0);
        run_scan(10);

        // Reset mid-RUN discards the trace
        start = 1'b1;
        num_cycles = CW'(20);
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_write(c, AW'(c + 1), DW'(c) + 32'hA0, 1'b0);
            tick();
        end
        wr_en = 1'b0;
        check_eq("pre_reset_valid", 64'(trace_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("post_reset_valid", 64'(trace_valid), 64'd0);
        check_eq("post_reset_busy", 64'(busy), 64'd0);
        check_eq("post_reset_done", 64'(done), 64'd0);
        check_eq("post_reset_errs", 64'(error_count), 64'd0);
        tick();
        check_eq("idle_holds", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
